// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with shadowed per-channel config.
// Optional build macro CLKDIV_PHASE_EN enables the per-channel phase offset.

module clock_divider_ch #(
  parameter int DW = 8
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          wr_i,
  input  logic          en_i,
  input  logic [DW-1:0] div_i,
  input  logic [DW-1:0] high_i,
  input  logic [DW-1:0] phase_i,
  input  logic          sync_i,
  output logic          clk_o,
  output logic          tick_o,
  output logic          pend_o
);
  logic          en_a_q, en_s_q, pend_q, clk_q, tick_q;
  logic [DW-1:0] div_a_q, high_a_q, div_s_q, high_s_q, cnt_q, cnt_d;
  logic [DW-1:0] div_n, start;
  logic          running, wrap, apply;

  assign running = en_a_q && (div_a_q != '0);
  // div_a-1 only matters while running, where div_a is known nonzero
  assign wrap    = running && (cnt_q == div_a_q - DW'(1));
  assign apply   = pend_q && (sync_i || !running || wrap);
  assign div_n   = apply ? div_s_q : div_a_q;

`ifdef CLKDIV_PHASE_EN
  logic [DW-1:0] phase_a_q, phase_s_q, phase_n;
  assign phase_n = apply ? phase_s_q : phase_a_q;
  assign start   = (phase_n < div_n) ? phase_n : '0;
`else
  logic unused_phase;
  assign unused_phase = ^{phase_i, div_n};
  assign start        = '0;
`endif

  always_comb begin
    cnt_d = cnt_q + DW'(1);
    if (sync_i)        cnt_d = start;
    else if (!running) cnt_d = apply ? start : '0;
    else if (wrap)     cnt_d = pend_q ? start : '0;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      en_a_q <= 1'b0; div_a_q <= '0; high_a_q <= '0;
      en_s_q <= 1'b0; div_s_q <= '0; high_s_q <= '0;
`ifdef CLKDIV_PHASE_EN
      phase_a_q <= '0; phase_s_q <= '0;
`endif
      pend_q <= 1'b0;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      // apply copies the old shadow; a same-cycle write becomes the next pending value
      if (apply) begin
        en_a_q <= en_s_q; div_a_q <= div_s_q; high_a_q <= high_s_q;
`ifdef CLKDIV_PHASE_EN
        phase_a_q <= phase_s_q;
`endif
      end
      if (wr_i) begin
        en_s_q <= en_i; div_s_q <= div_i; high_s_q <= high_i;
`ifdef CLKDIV_PHASE_EN
        phase_s_q <= phase_i;
`endif
      end
      pend_q <= wr_i | (pend_q & ~apply);
      cnt_q  <= cnt_d;
      clk_q  <= running && (cnt_q < high_a_q);
      tick_q <= running && (cnt_q == '0);
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;
endmodule

module clock_divider_multi #(
  parameter  int NUM_CH    = 4,
  parameter  int DIV_WIDTH = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 cfg_wr,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic                 cfg_en,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [DIV_WIDTH-1:0] cfg_high,
  input  logic [DIV_WIDTH-1:0] cfg_phase,
  input  logic                 sync,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    cfg_pending
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    // out-of-range cfg_ch matches no instance, so the write is dropped
    assign wr = cfg_wr && (cfg_ch == CH_W'(i));

    clock_divider_ch #(.DW(DIV_WIDTH)) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .wr_i    (wr),
      .en_i    (cfg_en),
      .div_i   (cfg_div),
      .high_i  (cfg_high),
      .phase_i (cfg_phase),
      .sync_i  (sync),
      .clk_o   (clk_out[i]),
      .tick_o  (tick[i]),
      .pend_o  (cfg_pending[i])
    );
  end
endmodule
